// File: rtl/data_memory_ctrl.sv
// 32 x 8 data memory with post-reset hardware clear, single-cycle stores and registered loads.
// Build option: define DMEM_WRITE_BYPASS_EN for write-first behaviour on a simultaneous load/store.
module data_memory_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              ready,
    output logic              err
);

    typedef enum logic {
        INIT,
        IDLE
    } state_t;

    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_next;
    logic [DATA_W-1:0] rdata_next;
    logic              rdata_valid_next;
    logic              ready_next;
    logic              err_next;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT;
            count       <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            ready       <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            rdata       <= rdata_next;
            rdata_valid <= rdata_valid_next;
            ready       <= ready_next;
            err         <= err_next;
        end
    end

    // The array has no reset; the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_next       = state;
        count_next       = count;
        rdata_next       = rdata;
        rdata_valid_next = 1'b0;
        err_next         = 1'b0;
        mem_we           = 1'b0;
        mem_waddr        = addr;
        mem_wdata        = wdata;

        case (state)
            INIT: begin
                mem_we     = 1'b1;
                mem_waddr  = count[ADDR_W-1:0];
                mem_wdata  = '0;
                count_next = count + 1'b1;
                if (count == LAST) begin
                    state_next = IDLE;
                end
                // Requests arriving before the clear completes are dropped and flagged.
                if (mem_read || mem_write) begin
                    err_next = 1'b1;
                end
            end
            IDLE: begin
                if (mem_write) begin
                    mem_we = 1'b1;
                end
                if (mem_read) begin
                    rdata_valid_next = 1'b1;
`ifdef DMEM_WRITE_BYPASS_EN
                    rdata_next = mem_write ? wdata : mem[addr];
`else
                    rdata_next = mem[addr];
`endif
                end
            end
            default: begin
                state_next = INIT;
            end
        endcase

        ready_next = (state_next == IDLE);
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed self-checking bench for data_memory_ctrl: clear sequence, loads/stores, INIT errors,
// simultaneous load/store ordering (honours DMEM_WRITE_BYPASS_EN) and mid-stream reset.
module tb_data_memory_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       ready;
    logic       err;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic [7:0] expBoth;

    data_memory_ctrl #(
        .ADDR_W(5),
        .DATA_W(8),
        .DEPTH (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .wdata      (wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .ready      (ready),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit past the next rising edge: outputs are stable, inputs safe to change.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [4:0] a,
                                 input logic [7:0] d);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Leaves rst_n released just after an edge, so the next rising edge is clear edge 1.
    task automatic doReset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);

`ifdef DMEM_WRITE_BYPASS_EN
        expBoth = 8'h22;
`else
        expBoth = 8'h11;
`endif

        // Reset state
        cycle();
        cycle();
        checkOutput("reset_ready", ready, 0);
        checkOutput("reset_rdata", rdata, 0);
        checkOutput("reset_valid", rdata_valid, 0);
        checkOutput("reset_err", err, 0);

        // Clear sweep: ready low after edges 1..31, high from edge 32 onwards
        rst_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            checkOutput($sformatf("init_ready_e%0d", k), ready, (k >= 32) ? 1 : 0);
            checkOutput($sformatf("init_err_e%0d", k), err, 0);
        end

        // Loads of cleared entries, back to back
        applyStimulus(1'b1, 1'b0, 5'd0, 8'h00);
        cycle();
        checkOutput("load0_rdata", rdata, 8'h00);
        checkOutput("load0_valid", rdata_valid, 1);
        applyStimulus(1'b1, 1'b0, 5'd15, 8'h00);
        cycle();
        checkOutput("load15_rdata", rdata, 8'h00);
        checkOutput("load15_valid", rdata_valid, 1);
        applyStimulus(1'b1, 1'b0, 5'd31, 8'h00);
        cycle();
        checkOutput("load31_rdata", rdata, 8'h00);
        checkOutput("load31_valid", rdata_valid, 1);
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        cycle();
        checkOutput("idle_valid", rdata_valid, 0);

        // Store then load next cycle
        applyStimulus(1'b0, 1'b1, 5'd7, 8'hA5);
        cycle();
        checkOutput("st7_valid", rdata_valid, 0);
        checkOutput("st7_err", err, 0);
        applyStimulus(1'b1, 1'b0, 5'd7, 8'h00);
        cycle();
        checkOutput("ld7_rdata", rdata, 8'hA5);
        checkOutput("ld7_valid", rdata_valid, 1);
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        cycle();
        checkOutput("ld7_valid_drop", rdata_valid, 0);
        checkOutput("ld7_rdata_hold", rdata, 8'hA5);
        applyStimulus(1'b1, 1'b0, 5'd8, 8'h00);
        cycle();
        checkOutput("ld8_untouched", rdata, 8'h00);

        // Simultaneous load and store
        applyStimulus(1'b0, 1'b1, 5'd9, 8'h11);
        cycle();
        applyStimulus(1'b1, 1'b1, 5'd9, 8'h22);
        cycle();
        checkOutput("both9_rdata", rdata, expBoth);
        checkOutput("both9_valid", rdata_valid, 1);
        checkOutput("both9_err", err, 0);
        applyStimulus(1'b1, 1'b0, 5'd9, 8'h00);
        cycle();
        checkOutput("ld9_after_both", rdata, 8'h22);

        // Store to the top entry, load it, then reset mid-cycle
        applyStimulus(1'b0, 1'b1, 5'd31, 8'h3C);
        cycle();
        applyStimulus(1'b1, 1'b0, 5'd31, 8'h00);
        cycle();
        checkOutput("ld31_rdata", rdata, 8'h3C);
        checkOutput("ld31_valid", rdata_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_rdata", rdata, 0);
        checkOutput("async_rst_valid", rdata_valid, 0);
        checkOutput("async_rst_ready", ready, 0);
        checkOutput("async_rst_err", err, 0);
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        cycle();
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            cycle();
        end
        checkOutput("reinit_ready", ready, 1);
        applyStimulus(1'b1, 1'b0, 5'd31, 8'h00);
        cycle();
        checkOutput("reinit_ld31", rdata, 8'h00);
        checkOutput("reinit_ld31_valid", rdata_valid, 1);

        // Requests during INIT are dropped and flagged
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        doReset();
        for (int k = 1; k <= 4; k++) begin
            cycle();
        end
        applyStimulus(1'b0, 1'b1, 5'd3, 8'hFF);
        cycle();
        checkOutput("initwr_err", err, 1);
        checkOutput("initwr_ready", ready, 0);
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        cycle();
        checkOutput("initwr_err_drop", err, 0);
        applyStimulus(1'b1, 1'b0, 5'd3, 8'h00);
        cycle();
        checkOutput("initrd_err", err, 1);
        checkOutput("initrd_valid", rdata_valid, 0);
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        for (int k = 8; k <= 32; k++) begin
            cycle();
        end
        checkOutput("initerr_ready", ready, 1);
        checkOutput("initerr_err_idle", err, 0);
        applyStimulus(1'b1, 1'b0, 5'd3, 8'h00);
        cycle();
        checkOutput("initerr_ld3", rdata, 8'h00);
        checkOutput("initerr_ld3_valid", rdata_valid, 1);
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        cycle();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
